fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch stage that drives the synchronous-read `instruction_memory` and hands fetched instructions to decode. It tracks the one-cycle read latency of the memory, supports back-pressure from decode through a one-entry hold buffer, and accepts zero-bubble PC redirects from execute. Output is a valid-qualified instruction/PC pair.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `IMEM_DEPTH`, 64: number of 32-bit words in instruction memory. Word indices at or above this value are out of range.
- `NOP_INSTR`, 32'h0000_0013: instruction substituted when no instruction is valid, and on fault.

Ports:
- `CLK` in, 1 bit: rising-edge clock, shared with instruction memory.
- `RESET_N` in, 1 bit: asynchronous, active-low reset.
- `IMEM_ADDR` out, 32 bits: word index to memory. Combinational.
- `IMEM_DATA` in, 32 bits: memory read data. Returns the word addressed one edge earlier.
- `STALL` in, 1 bit: decode cannot accept `INSTR` this cycle.
- `REDIRECT` in, 1 bit: load a new PC. This has the highest priority.
- `REDIRECT_PC` in, 32 bits: redirect target (byte address).
- `INSTR` out, 32 bits: instruction to decode.
- `INSTR_PC` out, 32 bits: byte address of `INSTR`.
- `INSTR_VALID` out, 1 bit: `INSTR`/`INSTR_PC` are meaningful.
- `FETCH_FAULT` out, 1 bit: `INSTR_PC` word index ≥ `IMEM_DEPTH`. Qualified by `INSTR_VALID`.

## Operation
Registers:
- `fetch_pc`: the address currently presented to memory.
- `req_pc`, `req_valid`: the address whose data is arriving this cycle.
- `hold_instr`: the hold buffer.
- `state`: one of {RUN, HELD}.

Address generation:
- `IMEM_ADDR` = `{2'b00, a[31:2]}`.
- `a` = `REDIRECT_PC` if `REDIRECT`, else `fetch_pc`.
- Bits [1:0] of any PC are ignored and forced to 0 internally.

Outputs:
- `INSTR_VALID` = `req_valid`. `INSTR_PC` = `req_pc`.
- `INSTR` = `hold_instr` in HELD, else `IMEM_DATA`.
- `INSTR` is forced to `NOP_INSTR` when `req_valid`=0 or fault.
- `FETCH_FAULT` = `req_valid && (req_pc[31:2] >= IMEM_DEPTH)`.

Define `advance = !STALL || !req_valid`. `consumed = req_valid && !STALL`.

Per-edge priority:
1. `REDIRECT`:
   - `req_pc`←`REDIRECT_PC`, `req_valid`←1, `fetch_pc`←`REDIRECT_PC+4`, `state`←RUN.
   - The current `INSTR` is discarded, even if `STALL`=1.
2. State RUN, `advance`:
   - `req_pc`←`fetch_pc`, `req_valid`←1, `fetch_pc`←`fetch_pc+4`.
3. State RUN, `STALL && req_valid`:
   - `hold_instr`←`IMEM_DATA` (the NOP-substituted value if faulted), `state`←HELD.
   - `fetch_pc` and `req_*` are unchanged.
4. State HELD, `STALL`:
   - All registers hold.
   - Memory keeps reading `fetch_pc`, so `IMEM_DATA` = word(`fetch_pc`).
5. State HELD, `!STALL`:
   - `state`←RUN, `req_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc+4`.
   - The next `INSTR` comes from `IMEM_DATA`, which already holds word(old `fetch_pc`).

Arithmetic and boundaries:
- PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0.
- Out-of-range fetches do not stall. `FETCH_FAULT` flags the instruction and `INSTR`=`NOP_INSTR`.
- Each fetched word is presented exactly once, in address order between redirects. No duplicates or drops across stalls.

## Timing
- Reset (async assert, `RESET_N`=0):
  - `fetch_pc`=`RESET_PC`, `req_pc`=`RESET_PC`, `req_valid`=0, `state`=RUN, `hold_instr`=`NOP_INSTR`.
  - Outputs: `INSTR_VALID`=0, `INSTR`=`NOP_INSTR`, `INSTR_PC`=`RESET_PC`, `FETCH_FAULT`=0, `IMEM_ADDR`=`RESET_PC>>2` (unless `REDIRECT`).
- Reset mid-stall or mid-redirect returns to these values immediately. No in-flight state survives.
- First valid instruction appears after the first rising edge following `RESET_N` deassertion: `INSTR_PC`=`RESET_PC`.
- Steady state, no stall: one instruction per cycle.
- Fetch latency is 1 edge, from `IMEM_ADDR` presented to `INSTR_VALID` with that PC.
- Redirect costs 0 bubbles. The edge that samples `REDIRECT` makes `INSTR_PC`=`REDIRECT_PC` valid on the next cycle.
- `STALL` with `INSTR_VALID`=0 has no effect.
- Release from HELD costs no bubble.

## Test plan
- Reset then free-run, memory word i = i: `INSTR_PC` = 0,4,8,… on consecutive cycles. `INSTR`=0,1,2,…. `INSTR_VALID` is 0 only in the first cycle.
- `STALL` for 3 cycles while `INSTR_PC`=8: `INSTR`=2 and `INSTR_PC`=8 held for 3 cycles. Then 12, 16 follow with no gap and no duplicate.
- `REDIRECT` with `REDIRECT_PC`=0x40 while `INSTR_PC`=8 and `STALL`=1: next cycle `INSTR_PC`=0x40, `INSTR`=16, state RUN. Then 0x44.
- `REDIRECT_PC`=0xF8 with `IMEM_DEPTH`=64: at `INSTR_PC`=0xFC, `FETCH_FAULT`=0. At 0x100, `FETCH_FAULT`=1 and `INSTR`=0x00000013.
- `REDIRECT_PC`=0x43: `INSTR_PC`=0x40. `REDIRECT_PC`=0xFFFF_FFFC: the next `INSTR_PC`=0 (wrap).
- Assert `RESET_N`=0 mid-stall (HELD): outputs return to reset values asynchronously. After release, the sequence restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter and fetch stage feeding decode from a synchronous-read instruction memory.
// Latency: one edge from IMEM_ADDR presentation to INSTR_VALID with that PC; redirects cost no bubble.
// Backpressure: STALL parks the in-flight word in a one-entry hold buffer; release costs no bubble.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_DATA,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_VALID,
    output logic        FETCH_FAULT
);

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
    localparam logic [29:0] DEPTH_W     = 30'(IMEM_DEPTH);

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic        req_valid, req_valid_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;

    logic [31:0] redirect_pc_al;
    logic [31:0] addr_sel;
    logic        advance;
    logic        fault;
    logic [31:0] instr_dat;

    assign redirect_pc_al = {REDIRECT_PC[31:2], 2'b00};

    // Redirect steers the memory this very cycle so its word lands with the new req_pc.
    assign addr_sel  = REDIRECT ? redirect_pc_al : fetch_pc;
    assign IMEM_ADDR = {2'b00, addr_sel[31:2]};

    assign advance = !STALL || !req_valid;
    assign fault   = req_valid && (req_pc[31:2] >= DEPTH_W);

    always_comb begin
        instr_dat = (state == HELD) ? hold_instr : IMEM_DATA;
        if (!req_valid || fault) begin
            instr_dat = NOP_INSTR;
        end
    end

    assign INSTR       = instr_dat;
    assign INSTR_PC    = req_pc;
    assign INSTR_VALID = req_valid;
    assign FETCH_FAULT = fault;

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        req_pc_nxt     = req_pc;
        req_valid_nxt  = req_valid;
        hold_instr_nxt = hold_instr;

        if (REDIRECT) begin
            req_pc_nxt    = redirect_pc_al;
            req_valid_nxt = 1'b1;
            fetch_pc_nxt  = redirect_pc_al + 32'd4;
            state_nxt     = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (advance) begin
                        req_pc_nxt    = fetch_pc;
                        req_valid_nxt = 1'b1;
                        fetch_pc_nxt  = fetch_pc + 32'd4;
                    end else begin
                        // Memory moves on to fetch_pc next edge, so park the current word.
                        hold_instr_nxt = instr_dat;
                        state_nxt      = HELD;
                    end
                end
                HELD: begin
                    if (!STALL) begin
                        // IMEM_DATA already carries word(fetch_pc) from the re-read while held.
                        req_pc_nxt   = fetch_pc;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC_AL;
            req_pc     <= RESET_PC_AL;
            req_valid  <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            req_pc     <= req_pc_nxt;
            req_valid  <= req_valid_nxt;
            hold_instr <= hold_instr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns word i = i at word index i.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] IMEM_ADDR;
    logic [31:0] imem_data;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        FETCH_FAULT;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) imem_data <= IMEM_ADDR;

    fetch_unit dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_DATA  (imem_data),
        .STALL      (STALL),
        .REDIRECT   (REDIRECT),
        .REDIRECT_PC(REDIRECT_PC),
        .INSTR      (INSTR),
        .INSTR_PC   (INSTR_PC),
        .INSTR_VALID(INSTR_VALID),
        .FETCH_FAULT(FETCH_FAULT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic v, input logic f);
        chk({tag, ".pc"},    INSTR_PC,           pc);
        chk({tag, ".instr"}, INSTR,              ins);
        chk({tag, ".valid"}, {31'd0, INSTR_VALID}, {31'd0, v});
        chk({tag, ".fault"}, {31'd0, FETCH_FAULT}, {31'd0, f});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N     = 1'b0;
        STALL       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        #12;
        expect_out("reset", 32'h0, 32'h13, 1'b0, 1'b0);
        chk("reset.addr", IMEM_ADDR, 32'h0);
        RESET_N = 1'b1;

        // Free run
        tick(); expect_out("run0", 32'h0, 32'h0, 1'b1, 1'b0);
        tick(); expect_out("run1", 32'h4, 32'h1, 1'b1, 1'b0);
        tick(); expect_out("run2", 32'h8, 32'h2, 1'b1, 1'b0);

        // Three-cycle stall at PC 8
        STALL = 1'b1;
        tick(); expect_out("stall1", 32'h8, 32'h2, 1'b1, 1'b0);
        tick(); expect_out("stall2", 32'h8, 32'h2, 1'b1, 1'b0);
        STALL = 1'b0;
        tick(); expect_out("rel0", 32'hC,  32'h3, 1'b1, 1'b0);
        tick(); expect_out("rel1", 32'h10, 32'h4, 1'b1, 1'b0);

        // Redirect back to 8, stall into HELD, then redirect to 0x40 while stalled
        REDIRECT = 1'b1; REDIRECT_PC = 32'h8;
        tick(); expect_out("rd8", 32'h8, 32'h2, 1'b1, 1'b0);
        REDIRECT = 1'b0; STALL = 1'b1;
        tick(); expect_out("held8", 32'h8, 32'h2, 1'b1, 1'b0);
        REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
        #1 chk("rd40.addr", IMEM_ADDR, 32'h10);
        tick(); expect_out("rd40", 32'h40, 32'h10, 1'b1, 1'b0);
        REDIRECT = 1'b0; STALL = 1'b0;
        tick(); expect_out("rd44", 32'h44, 32'h11, 1'b1, 1'b0);

        // Depth boundary
        REDIRECT = 1'b1; REDIRECT_PC = 32'hF8;
        tick(); expect_out("bnd_f8", 32'hF8, 32'h3E, 1'b1, 1'b0);
        REDIRECT = 1'b0;
        tick(); expect_out("bnd_fc",  32'hFC,  32'h3F, 1'b1, 1'b0);
        tick(); expect_out("bnd_100", 32'h100, 32'h13, 1'b1, 1'b1);
        tick(); expect_out("bnd_104", 32'h104, 32'h13, 1'b1, 1'b1);
        STALL = 1'b1;
        tick(); expect_out("bnd_hold", 32'h104, 32'h13, 1'b1, 1'b1);
        STALL = 1'b0;
        tick(); expect_out("bnd_108", 32'h108, 32'h13, 1'b1, 1'b1);

        // Misaligned redirect and PC wrap
        REDIRECT = 1'b1; REDIRECT_PC = 32'h43;
        #1 chk("mis.addr", IMEM_ADDR, 32'h10);
        tick(); expect_out("mis", 32'h40, 32'h10, 1'b1, 1'b0);
        REDIRECT_PC = 32'hFFFF_FFFC;
        tick(); expect_out("wrap_top", 32'hFFFF_FFFC, 32'h13, 1'b1, 1'b1);
        REDIRECT = 1'b0;
        tick(); expect_out("wrap0", 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while HELD
        STALL = 1'b1;
        tick(); expect_out("pre_rst_held", 32'h0, 32'h0, 1'b1, 1'b0);
        #1 RESET_N = 1'b0;
        #1;
        expect_out("rst_async", 32'h0, 32'h13, 1'b0, 1'b0);
        chk("rst_async.addr", IMEM_ADDR, 32'h0);
        #1 RESET_N = 1'b1;

        // STALL while nothing is valid must not block the first fetch
        tick(); expect_out("restart0", 32'h0, 32'h0, 1'b1, 1'b0);
        STALL = 1'b0;
        tick(); expect_out("restart1", 32'h4, 32'h1, 1'b1, 1'b0);
        tick(); expect_out("restart2", 32'h8, 32'h2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
